// File: rtl/wfrm_cmd_arbiter.sv
// Packet-granular round-robin arbiter feeding the waveform-formatter AXI-Stream input,
// with a mid-packet stall watchdog that closes a stuck packet with a zero-data tlast beat.
module wfrm_cmd_arbiter #(
   parameter int NUM_SRC  = 2,
   parameter int TIMEOUT  = 1024,
   parameter int TO_WIDTH = 16
) (
   input  logic                  axi_tclk,
   input  logic                  axi_treset,
   input  logic                  arb_enable,
   input  logic [32*NUM_SRC-1:0] s_axis_tdata,
   input  logic [NUM_SRC-1:0]    s_axis_tvalid,
   input  logic [NUM_SRC-1:0]    s_axis_tlast,
   output logic [NUM_SRC-1:0]    s_axis_tready,
   output logic [31:0]           m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic [NUM_SRC-1:0]    grant,
   output logic                  busy,
   output logic                  timeout_err,
   output logic [15:0]           pkt_count
);

   localparam int               IW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [IW:0]      NSRC     = (IW+1)'(NUM_SRC);
   localparam logic [IW-1:0]    LAST_IDX = IW'(NUM_SRC - 1);
   localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit               WD_ON    = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_XFER,
      S_ABORT
   } state_t;

   state_t              state;
   logic [IW-1:0]       gidx;
   logic [IW-1:0]       rr_ptr;
   logic [IW-1:0]       nxt_ptr;
   logic [IW-1:0]       pick;
   logic [NUM_SRC-1:0]  pick_oh;
   logic                found;
   logic [IW:0]         cand;
   logic [TO_WIDTH-1:0] wd_cnt;
   logic                g_valid;
   logic                g_last;
   logic [31:0]         g_data;

   // Granted-source mux with constant indices so non-power-of-two NUM_SRC stays in range.
   always_comb begin
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_data  = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (gidx == IW'(i)) begin
            g_valid = s_axis_tvalid[i];
            g_last  = s_axis_tlast[i];
            g_data  = s_axis_tdata[32*i +: 32];
         end
      end
   end

   // First requester at or after rr_ptr, wrapping modulo NUM_SRC.
   always_comb begin
      found   = 1'b0;
      pick    = '0;
      pick_oh = '0;
      cand    = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         cand = {1'b0, rr_ptr} + (IW+1)'(k);
         if (cand >= NSRC)
            cand = cand - NSRC;
         if (!found && s_axis_tvalid[cand[IW-1:0]]) begin
            found = 1'b1;
            pick  = cand[IW-1:0];
         end
      end
      pick_oh[pick] = 1'b1;
   end

   assign nxt_ptr = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;

   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      case (state)
         S_XFER: begin
            m_axis_tdata  = g_data;
            m_axis_tvalid = g_valid;
            m_axis_tlast  = g_last;
            s_axis_tready = grant & {NUM_SRC{m_axis_tready}};
         end
         S_ABORT: begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge axi_tclk or posedge axi_treset) begin
      if (axi_treset) begin
         state       <= S_IDLE;
         grant       <= '0;
         gidx        <= '0;
         rr_ptr      <= '0;
         wd_cnt      <= '0;
         pkt_count   <= '0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (arb_enable && found) begin
                  state  <= S_XFER;
                  gidx   <= pick;
                  grant  <= pick_oh;
                  wd_cnt <= '0;
                  busy   <= 1'b1;
               end
            end
            S_XFER: begin
               if (g_valid) begin
                  wd_cnt <= '0;
                  if (m_axis_tready && g_last) begin
                     state     <= S_IDLE;
                     grant     <= '0;
                     busy      <= 1'b0;
                     rr_ptr    <= nxt_ptr;
                     pkt_count <= pkt_count + 1'b1;
                  end
               end else if (WD_ON) begin
                  // Idle cycle TIMEOUT (counter at TIMEOUT-1) triggers the abort.
                  if (wd_cnt >= TO_LAST) begin
                     state       <= S_ABORT;
                     timeout_err <= 1'b1;
                  end else begin
                     wd_cnt <= wd_cnt + 1'b1;
                  end
               end
            end
            S_ABORT: begin
               if (m_axis_tready) begin
                  state     <= S_IDLE;
                  grant     <= '0;
                  busy      <= 1'b0;
                  rr_ptr    <= nxt_ptr;
                  pkt_count <= pkt_count + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               grant <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wfrm_cmd_arbiter.sv
// Scoreboard bench for wfrm_cmd_arbiter: directed packets push expected beats, a negedge monitor pops and compares.
module tb_wfrm_cmd_arbiter;

   logic        axi_tclk;
   logic        axi_treset;
   logic        arb_enable;
   logic [63:0] s_axis_tdata;
   logic [1:0]  s_axis_tvalid;
   logic [1:0]  s_axis_tlast;
   logic [1:0]  s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_tready;
   logic [1:0]  grant;
   logic        busy;
   logic        timeout_err;
   logic [15:0] pkt_count;

   logic [31:0] sd [2];
   logic        sv [2];
   logic        sl [2];

   assign s_axis_tdata  = {sd[1], sd[0]};
   assign s_axis_tvalid = {sv[1], sv[0]};
   assign s_axis_tlast  = {sl[1], sl[0]};

   wfrm_cmd_arbiter #(
      .NUM_SRC (2),
      .TIMEOUT (8),
      .TO_WIDTH(16)
   ) dut (
      .axi_tclk     (axi_tclk),
      .axi_treset   (axi_treset),
      .arb_enable   (arb_enable),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast (s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast (m_axis_tlast),
      .m_axis_tready(m_axis_tready),
      .grant        (grant),
      .busy         (busy),
      .timeout_err  (timeout_err),
      .pkt_count    (pkt_count)
   );

   initial axi_tclk = 1'b0;
   always #5 axi_tclk = ~axi_tclk;

   typedef struct {
      logic [31:0] d;
      logic        l;
      logic [1:0]  g;
   } exp_t;

   exp_t q[$];
   int   checks     = 0;
   int   errors     = 0;
   int   beats_seen = 0;
   int   to_cycles  = 0;
   int   exp_pkts   = 0;
   logic abandon    = 1'b0;
   logic t3_done    = 1'b0;

   function automatic logic [31:0] bd(input int src, input int pkt, input int beat);
      return {8'hDA, 8'(src), 8'(pkt), 8'(beat)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_pkt(input int src, input int pkt, input int nbeats);
      exp_t e;
      for (int b = 0; b < nbeats; b++) begin
         e.d = bd(src, pkt, b);
         e.l = (b == nbeats - 1);
         e.g = (src == 0) ? 2'b01 : 2'b10;
         q.push_back(e);
      end
      exp_pkts++;
   endtask

   task automatic push_abort(input int src);
      exp_t e;
      e.d = '0;
      e.l = 1'b1;
      e.g = (src == 0) ? 2'b01 : 2'b10;
      q.push_back(e);
   endtask

   // Offers beats from one source; stop_after >= 0 drops tvalid permanently after that many beats.
   task automatic send_pkt(input int src, input int pkt, input int nbeats, input int stop_after);
      logic done;
      for (int b = 0; b < nbeats; b++) begin
         if (b == stop_after) begin
            sv[src] = 1'b0;
            sl[src] = 1'b0;
            return;
         end
         sd[src] = bd(src, pkt, b);
         sl[src] = (b == nbeats - 1);
         sv[src] = 1'b1;
         done = 1'b0;
         for (int c = 0; c < 300 && !done && !abandon; c++) begin
            @(negedge axi_tclk);
            if (s_axis_tready[src]) begin
               @(posedge axi_tclk);
               #1;
               done = 1'b1;
            end
         end
         if (abandon) begin
            sv[src] = 1'b0;
            sl[src] = 1'b0;
            return;
         end
         checks++;
         if (!done) begin
            errors++;
            $display("FAIL handshake src%0d pkt%0d beat%0d got no_ready expected ready", src, pkt, b);
            sv[src] = 1'b0;
            return;
         end
      end
      sv[src] = 1'b0;
      sl[src] = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int c = 0; c < 200; c++) begin
         @(posedge axi_tclk);
         #1;
         if (!busy && q.size() == 0) return;
      end
      checks++;
      errors++;
      $display("FAIL %s_idle got busy=%0d pending=%0d expected 0 0", name, busy, q.size());
   endtask

   task automatic wait_beats(input int n);
      for (int c = 0; c < 200; c++) begin
         @(posedge axi_tclk);
         #1;
         if (beats_seen >= n) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_beats got %0d expected %0d", beats_seen, n);
   endtask

   // Monitor: compares every accepted output beat against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge axi_tclk);
         if (!axi_treset) begin
            checks++;
            if ((s_axis_tready & ~grant) != 2'b00) begin
               errors++;
               $display("FAIL tready_granted_only got tready=%b grant=%b", s_axis_tready, grant);
            end
            if (timeout_err) to_cycles++;
            if (m_axis_tvalid && m_axis_tready) begin
               beats_seen++;
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat got data=%h last=%b grant=%b expected none",
                           m_axis_tdata, m_axis_tlast, grant);
               end else begin
                  e = q.pop_front();
                  if (m_axis_tdata !== e.d || m_axis_tlast !== e.l || grant !== e.g) begin
                     errors++;
                     $display("FAIL beat got data=%h last=%b grant=%b expected data=%h last=%b grant=%b",
                              m_axis_tdata, m_axis_tlast, grant, e.d, e.l, e.g);
                  end
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int b0;
      int tc0;
      axi_treset    = 1'b1;
      arb_enable    = 1'b1;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sd[i] = '0;
         sv[i] = 1'b0;
         sl[i] = 1'b0;
      end
      #12;
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_tready", 32'(s_axis_tready), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pkt_count", 32'(pkt_count), 32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      @(posedge axi_tclk);
      #1;
      axi_treset = 1'b0;
      @(posedge axi_tclk);
      #1;

      // Both sources together: src0 first, then src1.
      push_pkt(0, 1, 3);
      push_pkt(1, 1, 3);
      fork
         send_pkt(0, 1, 3, -1);
         send_pkt(1, 1, 3, -1);
      join
      wait_idle("t1");
      chk("t1_pkt_count", 32'(pkt_count), 32'(exp_pkts));

      // Fairness: src0 back-to-back against continuous src1 alternates 0,1,0,1...
      for (int k = 0; k < 4; k++) begin
         push_pkt(0, 10 + k, 2);
         push_pkt(1, 20 + k, 2);
      end
      fork
         for (int k = 0; k < 4; k++) send_pkt(0, 10 + k, 2, -1);
         for (int k = 0; k < 4; k++) send_pkt(1, 20 + k, 2, -1);
      join
      wait_idle("t2");
      chk("t2_pkt_count", 32'(pkt_count), 32'(exp_pkts));

      // Backpressure toggling during a 5-beat packet.
      tc0 = to_cycles;
      push_pkt(0, 30, 5);
      t3_done = 1'b0;
      fork
         begin
            send_pkt(0, 30, 5, -1);
            t3_done = 1'b1;
         end
         begin
            for (int c = 0; c < 60 && !t3_done; c++) begin
               m_axis_tready = (c % 2 == 0);
               @(posedge axi_tclk);
               #1;
            end
            m_axis_tready = 1'b1;
         end
      join
      wait_idle("t3");
      chk("t3_no_timeout", 32'(to_cycles - tc0), 32'd0);
      chk("t3_pkt_count", 32'(pkt_count), 32'(exp_pkts));

      // Watchdog: src1 stalls after 2 beats, abort beat closes the packet, src0 follows.
      tc0 = to_cycles;
      push_pkt(1, 40, 2);
      exp_pkts--;
      q[q.size()-1].l = 1'b0;
      push_abort(1);
      exp_pkts++;
      push_pkt(0, 41, 2);
      fork
         send_pkt(1, 40, 6, 2);
         begin
            repeat (5) @(posedge axi_tclk);
            #1;
            send_pkt(0, 41, 2, -1);
         end
      join
      wait_idle("t4");
      chk("t4_timeout_pulse_cycles", 32'(to_cycles - tc0), 32'd1);
      chk("t4_pkt_count", 32'(pkt_count), 32'(exp_pkts));

      // arb_enable dropped mid-packet: packet completes, no grant until re-enabled.
      b0 = beats_seen;
      push_pkt(0, 50, 4);
      push_pkt(1, 51, 2);
      fork
         send_pkt(0, 50, 4, -1);
         begin
            wait_beats(b0 + 1);
            arb_enable = 1'b0;
            send_pkt(1, 51, 2, -1);
         end
         begin
            wait_beats(b0 + 4);
            for (int c = 0; c < 5; c++) begin
               chk("t5_disabled_grant", 32'(grant), 32'd0);
               @(posedge axi_tclk);
               #1;
            end
            arb_enable = 1'b1;
            @(posedge axi_tclk);
            #1;
            chk("t5_reenable_grant", 32'(grant), 32'b10);
         end
      join
      wait_idle("t5");
      chk("t5_pkt_count", 32'(pkt_count), 32'(exp_pkts));

      // Move rr_ptr to 1, then reset mid-packet of src1.
      push_pkt(0, 60, 1);
      send_pkt(0, 60, 1, -1);
      wait_idle("t6a");
      b0 = beats_seen;
      push_pkt(1, 61, 3);
      q[q.size()-1].d = bd(1, 61, 1);
      q[q.size()-1].l = 1'b0;
      q.delete(q.size() - 2);
      fork
         send_pkt(1, 61, 6, -1);
         begin
            wait_beats(b0 + 2);
            #2;
            axi_treset = 1'b1;
            abandon    = 1'b1;
            #1;
            chk("t6_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
            chk("t6_rst_tlast", 32'(m_axis_tlast), 32'd0);
            chk("t6_rst_tdata", m_axis_tdata, 32'd0);
            chk("t6_rst_tready", 32'(s_axis_tready), 32'd0);
            chk("t6_rst_grant", 32'(grant), 32'd0);
            chk("t6_rst_busy", 32'(busy), 32'd0);
         end
      join
      chk("t6_rst_queue_empty", 32'(q.size()), 32'd0);
      repeat (2) @(posedge axi_tclk);
      #1;
      axi_treset = 1'b0;
      abandon    = 1'b0;
      exp_pkts   = 0;
      chk("t6_post_pkt_count", 32'(pkt_count), 32'd0);
      // rr_ptr back at 0: src0 wins when both request.
      push_pkt(0, 62, 1);
      push_pkt(1, 63, 1);
      fork
         send_pkt(0, 62, 1, -1);
         send_pkt(1, 63, 1, -1);
      join
      wait_idle("t6");
      chk("t6_pkt_count", 32'(pkt_count), 32'(exp_pkts));
      chk("end_queue_empty", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
